pc_fetch_ctrl: RTL and testbench

Program-counter and instruction-fetch controller directly downstream of the target generator. Each cycle it selects the next instruction address from PC+4 or one of the three computed targets (jalr, branch, jal) and holds it in the PC register, which also feeds the target generator's CIS input. It issues instruction-memory fetches over a valid/ready handshake and buffers one redirect that arrives while a fetch is still waiting for memory. It also traps misaligned control-transfer targets.

---
 rtl/core_pkg.sv | 34 +++
 rtl/pc_target_mux.sv | 29 ++
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: PC source select, fetch FSM states,
// default vectors and the buffered-redirect payload.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4  = 2'd0,
        PC_SEL_JALR   = 2'd1,
        PC_SEL_BRANCH = 2'd2,
        PC_SEL_JAL    = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        PEND  = 2'd2
    } fetch_state_t;

    // Redirect held while the fetch in flight waits for memory
    typedef struct packed {
        logic [XLEN-1:0] load;
        logic [XLEN-1:0] tgt;
        logic            mis;
    } redir_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC source select plus misaligned-target trap substitution.
module pc_target_mux
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  pc_sel_t         sel,
    output logic [XLEN-1:0] load_val_c,
    output logic            mis_c,
    output logic [XLEN-1:0] tgt_c
);

    always_comb begin
        tgt_c = pc_plus4;
        case (sel)
            PC_SEL_JALR:   tgt_c = jalr;
            PC_SEL_BRANCH: tgt_c = branch;
            PC_SEL_JAL:    tgt_c = jal;
            default:       tgt_c = pc_plus4;
        endcase
        mis_c      = is_misaligned(tgt_c);
        load_val_c = mis_c ? TRAP_VECTOR : tgt_c;
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch handshake controller with a one-deep
// redirect buffer for redirects that arrive while a fetch is stuck in memory.
module pc_fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] jal,
    input  logic [1:0]  pc_sel,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_ready,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] bad_addr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    redir_t          rbuf_q, rbuf_d;
    logic            req_pending_q, req_pending_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic [XLEN-1:0] load_val_c, tgt_c;
    logic            mis_c;
    logic            accept_c, eff_redirect_c;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign flush      = flush_q;
    assign misalign   = misalign_q;
    assign bad_addr   = bad_addr_q;
    assign imem_valid = (state_q != BOOT) && (!stall || req_pending_q);

    assign accept_c       = imem_valid && imem_ready;
    assign eff_redirect_c = redirect && (pc_sel != 2'd0);

    pc_target_mux #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_mux (
        .pc_plus4   (pc_plus4),
        .jalr       (jalr),
        .branch     (branch),
        .jal        (jal),
        .sel        (pc_sel_t'(pc_sel)),
        .load_val_c (load_val_c),
        .mis_c      (mis_c),
        .tgt_c      (tgt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            rbuf_q        <= '0;
            req_pending_q <= 1'b0;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            bad_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rbuf_q        <= rbuf_d;
            req_pending_q <= req_pending_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            bad_addr_q    <= bad_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rbuf_d        = rbuf_q;
        req_pending_d = imem_valid && !imem_ready;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        bad_addr_d    = bad_addr_q;

        case (state_q)
            BOOT: begin
                state_d       = FETCH;
                req_pending_d = 1'b0;
            end
            FETCH: begin
                if (eff_redirect_c) begin
                    if (req_pending_q && !imem_ready) begin
                        rbuf_d  = '{load: load_val_c, tgt: tgt_c, mis: mis_c};
                        state_d = PEND;
                    end else begin
                        // An unaccepted first-cycle request at the old PC is withdrawn
                        pc_d          = load_val_c;
                        flush_d       = 1'b1;
                        misalign_d    = mis_c;
                        req_pending_d = 1'b0;
                        if (mis_c) begin
                            bad_addr_d = tgt_c;
                        end
                    end
                end else if (accept_c) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                if (accept_c) begin
                    pc_d       = rbuf_q.load;
                    flush_d    = 1'b1;
                    misalign_d = rbuf_q.mis;
                    state_d    = FETCH;
                    if (rbuf_q.mis) begin
                        bad_addr_d = rbuf_q.tgt;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl against a transaction-level model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] jalr, branch, jal;
    logic [1:0]  pc_sel;
    logic        redirect, stall, imem_ready;
    logic        imem_valid;
    logic [31:0] imem_addr, pc, pc_plus4, bad_addr;
    logic        flush, misalign;

    pc_fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .clk(clk), .rst_n(rst_n), .jalr(jalr), .branch(branch), .jal(jal),
        .pc_sel(pc_sel), .redirect(redirect), .stall(stall),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_addr(imem_addr),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .misalign(misalign),
        .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        mis;
        logic [31:0] bad;
    } exp_t;

    typedef struct {
        logic [31:0] load;
        logic [31:0] raw;
        logic        mis;
    } redir_t;

    exp_t        exp_q[$];
    logic [31:0] fetch_q[$];
    redir_t      buf_q[$];

    int checks = 0;
    int errors = 0;

    bit          m_booted;
    bit          m_preq;
    logic [31:0] m_pc;
    logic        m_flush, m_mis;
    logic [31:0] m_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booted = 1'b0;
        m_preq   = 1'b0;
        m_pc     = RV;
        m_flush  = 1'b0;
        m_mis    = 1'b0;
        m_bad    = '0;
        buf_q.delete();
    endtask

    // Drive one cycle of inputs, record expected outputs, advance the model
    task automatic apply(input bit st, input bit rdy, input bit rd, input logic [1:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        exp_t        e;
        redir_t      r;
        bit          valid, acc, loaded;
        logic [31:0] tgt;
        logic        n_flush, n_mis;

        stall = st; imem_ready = rdy; redirect = rd; pc_sel = sel;
        jalr = a; branch = b; jal = c;

        valid = m_booted && (!st || m_preq);
        acc   = valid && rdy;
        e.pc = m_pc; e.valid = valid; e.flush = m_flush; e.mis = m_mis; e.bad = m_bad;
        exp_q.push_back(e);
        if (acc) fetch_q.push_back(m_pc);

        case (sel)
            2'd1:    tgt = a;
            2'd2:    tgt = b;
            2'd3:    tgt = c;
            default: tgt = m_pc + 32'd4;
        endcase
        n_flush = 1'b0; n_mis = 1'b0; loaded = 1'b0;

        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (buf_q.size() != 0) begin
            if (acc) begin
                r = buf_q.pop_front();
                m_pc = r.load; n_flush = 1'b1; n_mis = r.mis; loaded = 1'b1;
                if (r.mis) m_bad = r.raw;
            end
        end else if (rd && sel != 2'd0) begin
            r.raw  = tgt;
            r.mis  = (tgt % 4) != 0;
            r.load = r.mis ? TV : tgt;
            if (m_preq && !rdy) begin
                buf_q.push_back(r);
            end else begin
                m_pc = r.load; n_flush = 1'b1; n_mis = r.mis; loaded = 1'b1;
                if (r.mis) m_bad = r.raw;
            end
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        m_preq  = valid && !rdy && !loaded;
        m_flush = n_flush;
        m_mis   = n_mis;
    endtask

    task automatic step(input bit st, input bit rdy, input bit rd, input logic [1:0] sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        @(negedge clk);
        apply(st, rdy, rd, sel, a, b, c);
    endtask

    task automatic idle(input bit st, input bit rdy);
        step(st, rdy, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RV);
        chk({tag, "_valid"}, 32'(imem_valid), 32'd0);
        chk({tag, "_flush"}, 32'(flush), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_bad_addr"}, bad_addr, 32'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, released at a falling edge
    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0; imem_ready = 1'b0; redirect = 1'b0; pc_sel = 2'd0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: compare cycle outputs and every accepted fetch address
    initial begin
        exp_t e;
        logic [31:0] fa;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("imem_addr", imem_addr, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("imem_valid", 32'(imem_valid), 32'(e.valid));
                chk("flush", 32'(flush), 32'(e.flush));
                chk("misalign", 32'(misalign), 32'(e.mis));
                chk("bad_addr", bad_addr, e.bad);
                if (rst_n && imem_valid && imem_ready) begin
                    if (fetch_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch: unexpected accept at addr %h", imem_addr);
                    end else begin
                        fa = fetch_q.pop_front();
                        chk("fetch_addr", imem_addr, fa);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] ta, tb, tc;
        rst_n = 1'b0;
        stall = 1'b0; imem_ready = 1'b1; redirect = 1'b0; pc_sel = 2'd0;
        jalr = '0; branch = '0; jal = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);

        // Streaming fetch from the reset vector
        repeat (4) idle(1'b0, 1'b1);
        // JAL redirect with memory ready
        step(1'b0, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 32'h200);
        repeat (3) idle(1'b0, 1'b1);
        // Redirect buffered behind a stuck fetch; a younger redirect is dropped
        idle(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h80, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 32'h300, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) idle(1'b0, 1'b1);
        // Misaligned JALR traps
        step(1'b0, 1'b1, 1'b1, 2'd1, 32'h1002, 32'h0, 32'h0);
        repeat (3) idle(1'b0, 1'b1);
        // PC+4 wrap at the top of the address space
        step(1'b0, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 32'hFFFF_FFFC);
        repeat (3) idle(1'b0, 1'b1);
        // Stall without pending request, then stall with redirect
        repeat (2) idle(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 2'd2, 32'h0, 32'h500, 32'h0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        // Redirect with PC+4 select is ignored
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h0);
        idle(1'b0, 1'b1);
        // Reset while a redirect is buffered
        idle(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 32'h700);
        do_reset();
        repeat (4) idle(1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
            end else begin
                ta = $urandom; tb = $urandom; tc = $urandom;
                if ($urandom_range(7) != 0) ta[1:0] = 2'b00;
                if ($urandom_range(7) != 0) tb[1:0] = 2'b00;
                if ($urandom_range(7) != 0) tc[1:0] = 2'b00;
                step($urandom_range(3) == 0, $urandom_range(4) > 1,
                     $urandom_range(9) < 3, 2'($urandom_range(3)), ta, tb, tc);
            end
        end

        @(negedge clk);
        #2;
        chk("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
